// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and occupancy encoding for the ID/EX skid stage
package pipe_pkg;

    // Control value carried by a bubble: no register write, no memory write.
    localparam logic [7:0] CTRL_NOP = 8'h00;

    // ID/EX control bundle bit positions.
    localparam int GPRWR_BIT = 7;
    localparam int BSEL_BIT  = 6;
    localparam int DMWR_BIT  = 5;
    localparam int MTR_BIT   = 4;
    localparam int ALUOP_MSB = 3;
    localparam int ALUOP_LSB = 0;

    // Number of entries held by the stage.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_state_t;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one storage slot (valid, data, ctrl) of the skid stage
module pipe_slot #(
    parameter int              DW       = 103,
    parameter int              CW       = 8,
    parameter logic [CW-1:0]   CTRL_NOP = {CW{1'b0}}
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          clear,
    input  logic [DW-1:0] d_data,
    input  logic [CW-1:0] d_ctrl,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic [CW-1:0] ctrl
);

    // Clear wins over load; a cleared slot keeps its data but drops to a NOP control word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= CTRL_NOP;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= CTRL_NOP;
        end else if (load) begin
            valid <= 1'b1;
            data  <= d_data;
            ctrl  <= d_ctrl;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - handshaked ID/EX pipeline register with 2-entry skid buffer
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int            DW       = 103,
    parameter int            CW       = 8,
    parameter logic [CW-1:0] CTRL_NOP = {CW{1'b0}}
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    input  logic [CW-1:0] i_ctrl,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic [CW-1:0] o_ctrl,
    output logic [1:0]    o_occ
);

    occ_state_t    occ_q;
    occ_state_t    occ_d;

    logic          main_v;
    logic [DW-1:0] main_data;
    logic [CW-1:0] main_ctrl;
    logic          skid_v;
    logic [DW-1:0] skid_data;
    logic [CW-1:0] skid_ctrl;

    logic          main_load;
    logic          main_clr;
    logic          main_from_skid;
    logic          skid_load;
    logic          skid_clr;
    logic [DW-1:0] main_d_data;
    logic [CW-1:0] main_d_ctrl;

    logic          in_fire;
    logic          out_fire;

    // Ready and valid come straight from slot flops, so no ready path crosses the stage.
    assign o_ready  = !skid_v;
    assign o_valid  = main_v;
    assign in_fire  = i_valid & o_ready;
    assign out_fire = o_valid & i_ready;

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= EMPTY;
        end else begin
            occ_q <= occ_d;
        end
    end

    // Next occupancy and slot enables; flush overrides every transfer.
    always_comb begin
        occ_d          = occ_q;
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
            occ_d    = EMPTY;
        end else begin
            case (occ_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_load = 1'b1;
                        occ_d     = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        skid_load = 1'b1;
                        occ_d     = FULL;
                    end else if (out_fire) begin
                        main_clr = 1'b1;
                        occ_d    = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                        occ_d          = ONE;
                    end
                end
                default: begin
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                    occ_d    = EMPTY;
                end
            endcase
        end
    end

    // Main refills from the skid slot when draining a full stage, otherwise from upstream.
    always_comb begin
        main_d_data = i_data;
        main_d_ctrl = i_ctrl;
        if (main_from_skid) begin
            main_d_data = skid_data;
            main_d_ctrl = skid_ctrl;
        end
    end

    pipe_slot #(
        .DW       (DW),
        .CW       (CW),
        .CTRL_NOP (CTRL_NOP)
    ) u_main (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (main_load),
        .clear  (main_clr),
        .d_data (main_d_data),
        .d_ctrl (main_d_ctrl),
        .valid  (main_v),
        .data   (main_data),
        .ctrl   (main_ctrl)
    );

    pipe_slot #(
        .DW       (DW),
        .CW       (CW),
        .CTRL_NOP (CTRL_NOP)
    ) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (skid_load),
        .clear  (skid_clr),
        .d_data (i_data),
        .d_ctrl (i_ctrl),
        .valid  (skid_v),
        .data   (skid_data),
        .ctrl   (skid_ctrl)
    );

    // A bubble never presents a live control word downstream.
    assign o_data = main_data;
    assign o_ctrl = main_v ? main_ctrl : CTRL_NOP;
    assign o_occ  = occ_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - scoreboard bench for pipe_skid_reg
module tb_pipe_skid_reg;

    localparam int DW = 103;
    localparam int CW = 8;

    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } entry_t;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data;
    logic [CW-1:0] i_ctrl;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
    logic [CW-1:0] o_ctrl;
    logic [1:0]    o_occ;

    entry_t sb[$];
    int     n_cmp  = 0;
    int     n_fail = 0;

    pipe_skid_reg #(.DW(DW), .CW(CW), .CTRL_NOP(8'h00)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_ctrl  (i_ctrl),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_ctrl  (o_ctrl),
        .o_occ   (o_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare all outputs against the scoreboard view of the stage.
    task automatic check_state(input string tag);
        int n;
        n = sb.size();
        chk({tag, ".occ"},   128'(o_occ),   128'(n));
        chk({tag, ".ready"}, 128'(o_ready), 128'(n < 2));
        chk({tag, ".valid"}, 128'(o_valid), 128'(n != 0));
        if (n != 0) begin
            chk({tag, ".data"}, 128'(o_data), 128'(sb[0].d));
            chk({tag, ".ctrl"}, 128'(o_ctrl), 128'(sb[0].c));
        end else begin
            chk({tag, ".nop"}, 128'(o_ctrl), 128'(0));
        end
    endtask

    // One cycle: drive at the falling edge, check, update the model, cross the rising edge.
    task automatic step(input string tag, input logic v, input logic [DW-1:0] d,
                        input logic [CW-1:0] c, input logic r, input logic f);
        bit in_f;
        bit out_f;
        entry_t e;
        i_valid = v;
        i_data  = d;
        i_ctrl  = c;
        i_ready = r;
        flush   = f;
        #1;
        check_state(tag);
        out_f = (sb.size() != 0) && r;
        in_f  = v && (sb.size() < 2) && !f;
        if (f) begin
            sb.delete();
        end else begin
            if (out_f) void'(sb.pop_front());
            if (in_f) begin
                e.d = d;
                e.c = c;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [127:0] x;
        x = {$urandom, $urandom, $urandom, $urandom};
        return x[DW-1:0];
    endfunction

    initial begin
        logic          pend_v;
        logic [DW-1:0] pend_d;
        logic [CW-1:0] pend_c;
        logic          v;
        logic          r;
        logic          f;

        rst_n   = 1'b0;
        flush   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
        i_ctrl  = '0;
        @(negedge clk);
        @(negedge clk);
        check_state("reset");
        chk("reset.data", 128'(o_data), 128'(0));
        rst_n = 1'b1;

        // Reset and stream 1..8 at full rate.
        for (int k = 1; k <= 8; k++)
            step("stream", 1'b1, DW'(k), CW'(k), 1'b1, 1'b0);
        step("stream_drain", 1'b0, '0, '0, 1'b1, 1'b0);
        step("stream_idle", 1'b0, '0, '0, 1'b1, 1'b0);

        // Backpressure: A, B, C with downstream stalled from cycle 2.
        step("bp_a",  1'b1, DW'('hA), 8'h1A, 1'b1, 1'b0);
        step("bp_b",  1'b1, DW'('hB), 8'h1B, 1'b0, 1'b0);
        step("bp_c0", 1'b1, DW'('hC), 8'h1C, 1'b0, 1'b0);
        step("bp_c1", 1'b1, DW'('hC), 8'h1C, 1'b1, 1'b0);
        step("bp_c2", 1'b1, DW'('hC), 8'h1C, 1'b1, 1'b0);
        step("bp_d0", 1'b0, '0, '0, 1'b1, 1'b0);
        step("bp_d1", 1'b0, '0, '0, 1'b1, 1'b0);

        // Flush while full, with an input presented in the same cycle.
        step("fl_d", 1'b1, DW'('hD), 8'hF3, 1'b0, 1'b0);
        step("fl_e", 1'b1, DW'('hE), 8'hF3, 1'b0, 1'b0);
        step("fl_f", 1'b1, DW'('hF), 8'hF3, 1'b0, 1'b1);
        step("fl_after", 1'b0, '0, '0, 1'b0, 1'b0);
        step("fl_g", 1'b1, DW'('h6), 8'h06, 1'b1, 1'b0);
        step("fl_drain", 1'b0, '0, '0, 1'b1, 1'b0);
        step("fl_idle", 1'b0, '0, '0, 1'b1, 1'b0);

        // Simultaneous fire at occupancy 1.
        step("sim_x", 1'b1, DW'('h58), 8'h58, 1'b0, 1'b0);
        step("sim_y", 1'b1, DW'('h59), 8'h59, 1'b1, 1'b0);
        step("sim_head", 1'b0, '0, '0, 1'b1, 1'b0);
        step("sim_idle", 1'b0, '0, '0, 1'b1, 1'b0);

        // Asynchronous reset between edges while full.
        step("ar_p", 1'b1, DW'('h70), 8'h91, 1'b0, 1'b0);
        step("ar_q", 1'b1, DW'('h71), 8'h92, 1'b0, 1'b0);
        i_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check_state("async_rst");
        chk("async_rst.data", 128'(o_data), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step("ar_rel", 1'b1, DW'('h72), 8'h93, 1'b1, 1'b0);
        step("ar_drain", 1'b0, '0, '0, 1'b1, 1'b0);
        step("ar_idle", 1'b0, '0, '0, 1'b1, 1'b0);

        // Random traffic; upstream holds a presented entry until it is taken.
        pend_v = 1'b0;
        pend_d = '0;
        pend_c = '0;
        for (int n = 0; n < 10000; n++) begin
            if (!pend_v) begin
                pend_v = ($urandom_range(3) != 0);
                pend_d = rnd_data();
                pend_c = CW'($urandom);
            end
            v = pend_v;
            r = ($urandom_range(2) != 0);
            f = ($urandom_range(63) == 0);
            if (f || (v && sb.size() < 2)) pend_v = 1'b0;
            step("rand", v, pend_d, pend_c, r, f);
        end
        step("final", 1'b0, '0, '0, 1'b1, 1'b0);
        step("final", 1'b0, '0, '0, 1'b1, 1'b0);
        step("final", 1'b0, '0, '0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
